// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel synchroniser/debouncer.
package debounce_pkg;

  // Gray-ordered so adjacent states differ in one bit.
  typedef enum logic [1:0] {
    ST_LO     = 2'b00,
    ST_CHK_HI = 2'b01,
    ST_HI     = 2'b11,
    ST_CHK_LO = 2'b10
  } t_deb_state;

  function automatic int unsigned deb_timer_width(input int unsigned t_rise,
                                                  input int unsigned t_fall);
    int unsigned t_max;
    t_max = (t_rise > t_fall) ? t_rise : t_fall;
    return $clog2(t_max + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser chain, qualification FSM/timer and registered level.
// Edge-pulse flops exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned T_RISE      = 20,
  parameter int unsigned T_FALL      = 20
) (
  input  logic i_clk_20mhz,
  input  logic i_rst_20mhz,
  input  logic ei_line,
  output logic o_deb,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned   TW        = deb_timer_width(T_RISE, T_FALL);
  localparam logic [TW-1:0] RISE_LAST = TW'(T_RISE - 1);
  localparam logic [TW-1:0] FALL_LAST = TW'(T_FALL - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  t_deb_state             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   deb_q, deb_d;
  logic                   s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Next state: timer counts qualifying samples, held at 0 in stable states.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ei_line};
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      ST_LO: begin
        if (s_sync) begin
          if (T_RISE == 1) begin
            state_d = ST_HI;
          end else begin
            state_d = ST_CHK_HI;
            timer_d = TIMER_ONE;
          end
        end
      end
      ST_CHK_HI: begin
        if (!s_sync)                    state_d = ST_LO;
        else if (timer_q == RISE_LAST)  state_d = ST_HI;
        else                            timer_d = timer_q + TIMER_ONE;
      end
      ST_HI: begin
        if (!s_sync) begin
          if (T_FALL == 1) begin
            state_d = ST_LO;
          end else begin
            state_d = ST_CHK_LO;
            timer_d = TIMER_ONE;
          end
        end
      end
      ST_CHK_LO: begin
        if (s_sync)                     state_d = ST_HI;
        else if (timer_q == FALL_LAST)  state_d = ST_LO;
        else                            timer_d = timer_q + TIMER_ONE;
      end
      default: state_d = ST_LO;
    endcase
    deb_d = (state_d == ST_HI) || (state_d == ST_CHK_LO);
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      sync_q  <= '0;
      state_q <= ST_LO;
      timer_q <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      deb_q   <= deb_d;
    end
  end

  assign o_deb = deb_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulses coincide with the first cycle o_deb shows its new level.
  always_comb begin
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_debouncer.sv
// N independent synchroniser+debouncer channels for external status lines.
// Optional edge pulses on o_rise/o_fall via DEBOUNCE_EDGE_PULSE_EN.
module multi_channel_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned T_RISE      = 20,
  parameter int unsigned T_FALL      = 20
) (
  input  logic              i_clk_20mhz,
  input  logic              i_rst_20mhz,
  input  logic [NUM_CH-1:0] ei_lines,
  output logic [NUM_CH-1:0] o_deb,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .T_RISE      (T_RISE),
      .T_FALL      (T_FALL)
    ) u_ch (
      .i_clk_20mhz (i_clk_20mhz),
      .i_rst_20mhz (i_rst_20mhz),
      .ei_line     (ei_lines[i]),
      .o_deb       (o_deb[i]),
      .o_rise      (o_rise[i]),
      .o_fall      (o_fall[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Self-checking bench for multi_channel_debouncer: directed tables, corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_multi_channel_debouncer;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned T_RISE      = 20;
  localparam int unsigned T_FALL      = 20;
  localparam int          LAT         = int'(SYNC_STAGES + T_RISE);
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] lines = '0;
  logic [NUM_CH-1:0] deb, rise, fall;
  logic              a_line = 1'b0;
  logic [0:0]        a_deb, a_rise, a_fall;

  always #25 clk = ~clk;

  multi_channel_debouncer #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .T_RISE(T_RISE), .T_FALL(T_FALL)
  ) dut (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst),
    .ei_lines    (lines),
    .o_deb       (deb),
    .o_rise      (rise),
    .o_fall      (fall)
  );

  multi_channel_debouncer #(
    .NUM_CH(1), .SYNC_STAGES(2), .T_RISE(1), .T_FALL(5)
  ) dut_a (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst),
    .ei_lines    (a_line),
    .o_deb       (a_deb),
    .o_rise      (a_rise),
    .o_fall      (a_fall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: synced value is the pin seen SYNC_STAGES edges ago; the
  // output flips once T consecutive synced samples disagree with it.
  logic [NUM_CH-1:0] pin_hist [$];
  logic [NUM_CH-1:0] m_deb  = '0;
  logic [NUM_CH-1:0] m_rise = '0;
  logic [NUM_CH-1:0] m_fall = '0;
  int                m_run [NUM_CH];
  bit                m_valid = 1'b0;

  task automatic model_update();
    logic [NUM_CH-1:0] s;
    if (rst) begin
      pin_hist.delete();
      m_deb = '0; m_rise = '0; m_fall = '0;
      foreach (m_run[c]) m_run[c] = 0;
      m_valid = 1'b1;
    end else begin
      pin_hist.push_back(lines);
      s = (pin_hist.size() > int'(SYNC_STAGES)) ? pin_hist.pop_front() : '0;
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (s[c] != m_deb[c]) m_run[c]++;
        else                  m_run[c] = 0;
        if (m_run[c] == (m_deb[c] ? int'(T_FALL) : int'(T_RISE))) begin
          m_deb[c] = ~m_deb[c];
          m_run[c] = 0;
          if (m_deb[c]) m_rise[c] = 1'b1;
          else          m_fall[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [NUM_CH-1:0] er, ef;
    if (m_valid) begin
      er = EDGE_EN ? m_rise : '0;
      ef = EDGE_EN ? m_fall : '0;
      n_tests++;
      if (deb !== m_deb) begin
        n_fail++;
        $display("FAIL model_deb t=%0t got %b exp %b", $time, deb, m_deb);
      end
      n_tests++;
      if (rise !== er || fall !== ef) begin
        n_fail++;
        $display("FAIL model_edges t=%0t got rise=%b fall=%b exp rise=%b fall=%b",
                 $time, rise, fall, er, ef);
      end
    end
  endtask

  // One clock: model sees the same inputs as the DUT edge, outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic wait_level(input int ch, input logic lvl, input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (deb[ch] === lvl) begin
        cyc = i;
        break;
      end
    end
  endtask

  typedef struct {
    int ch;
    int hi_len;
    int exp_first;   // cycles from pin edge to o_deb high, 0 = never
  } pulse_vec_t;

  typedef struct {
    logic pin;
    logic exp_deb;
  } asym_vec_t;

  initial begin
    pulse_vec_t pv [6];
    asym_vec_t  av [20];
    int cyc, first, nf;
    logic prev_exp;

    pv[0] = '{ch: 1, hi_len: 19, exp_first: 0};
    pv[1] = '{ch: 1, hi_len: 20, exp_first: LAT};
    pv[2] = '{ch: 1, hi_len: 1,  exp_first: 0};
    pv[3] = '{ch: 3, hi_len: 25, exp_first: LAT};
    pv[4] = '{ch: 2, hi_len: 5,  exp_first: 0};
    pv[5] = '{ch: 2, hi_len: 40, exp_first: LAT};
    for (int i = 0; i < 20; i++) begin
      av[i].pin     = (i == 0) || (i >= 10 && i <= 11) || (i >= 16);
      av[i].exp_deb = (i >= 2 && i <= 6) || (i >= 12);
    end

    // Reset held 3 cycles with all pins high
    rst = 1'b1; lines = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_int("reset_deb",  int'(deb),  0);
      expect_int("reset_rise", int'(rise), 0);
      expect_int("reset_fall", int'(fall), 0);
    end
    rst = 1'b0; lines = '0;
    repeat (30) step();

    // Clean rise / fall on ch0
    lines[0] = 1'b1;
    wait_level(0, 1'b1, 40, cyc);
    expect_int("clean_rise_lat", cyc, LAT);
    expect_int("clean_rise_pulse", int'(rise[0]), int'(EDGE_EN));
    expect_int("clean_rise_others", int'(deb[3:1]), 0);
    step();
    expect_int("clean_rise_pulse_end", int'(rise[0]), 0);
    lines[0] = 1'b0;
    wait_level(0, 1'b0, 40, cyc);
    expect_int("clean_fall_lat", cyc, LAT - 0);
    expect_int("clean_fall_pulse", int'(fall[0]), int'(EDGE_EN));
    repeat (10) step();

    // Pulse-width table: glitch rejection and qualification latency
    foreach (pv[k]) begin
      lines[pv[k].ch] = 1'b1;
      first = 0;
      for (int c = 1; c <= pv[k].hi_len + LAT + 5; c++) begin
        step();
        if (c == pv[k].hi_len) lines[pv[k].ch] = 1'b0;
        if (first == 0 && deb[pv[k].ch] === 1'b1) first = c;
      end
      expect_int($sformatf("pulse_ch%0d_len%0d", pv[k].ch, pv[k].hi_len), first, pv[k].exp_first);
      repeat (30) step();
    end

    // Fall with bounce on ch2
    lines[2] = 1'b1;
    wait_level(2, 1'b1, 40, cyc);
    expect_int("bounce_rise_lat", cyc, LAT);
    repeat (5) step();
    nf = 0;
    lines[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); nf += int'(fall[2]); end
    lines[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); nf += int'(fall[2]); end
    expect_int("bounce_hold", int'(deb[2]), 1);
    lines[2] = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      nf += int'(fall[2]);
      if (cyc < 0 && deb[2] === 1'b0) cyc = i;
    end
    expect_int("bounce_fall_lat", cyc, LAT);
    expect_int("bounce_fall_pulses", nf, EDGE_EN ? 1 : 0);

    // Independence: ch0 and ch3 toggle with unrelated periods
    for (int i = 0; i < 400; i++) begin
      lines[0] = 1'(((i / 37) % 2));
      lines[3] = 1'(((i + 11) / 53) % 2);
      step();
    end
    lines = '0;
    repeat (30) step();

    // Reset while ch0 is qualifying a fall at count 10
    lines[0] = 1'b1;
    wait_level(0, 1'b1, 40, cyc);
    expect_int("midrst_rise_lat", cyc, LAT);
    repeat (3) step();
    lines[0] = 1'b0;
    repeat (12) step();
    expect_int("midrst_still_high", int'(deb[0]), 1);
    rst = 1'b1; lines[0] = 1'b1;
    step();
    expect_int("midrst_deb_cleared", int'(deb[0]), 0);
    expect_int("midrst_no_fall", int'(fall[0]), 0);
    rst = 1'b0;
    wait_level(0, 1'b1, 40, cyc);
    expect_int("midrst_reassert_lat", cyc, LAT);
    lines = '0;
    repeat (30) step();

    // Randomized toggling with occasional resets
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < int'(NUM_CH); c++)
        if ($urandom_range(0, 15) == 0) lines[c] = ~lines[c];
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0; lines = '0;
    repeat (30) step();

    // Asymmetric build: T_RISE=1, T_FALL=5
    prev_exp = 1'b0;
    foreach (av[i]) begin
      a_line = av[i].pin;
      step();
      expect_int($sformatf("asym_deb_%0d", i), int'(a_deb), int'(av[i].exp_deb));
      expect_int($sformatf("asym_rise_%0d", i), int'(a_rise),
                 int'(EDGE_EN && av[i].exp_deb && !prev_exp));
      prev_exp = av[i].exp_deb;
    end
    a_line = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
